cache_fill_fsm: RTL

- Initiator for the 16-bit byte-addressed memory port (addr, enable, wr, data in/out); drives a pipelined main memory that returns read data with a valid strobe.
- On a cache miss, fetches the enclosing 16-byte block as eight sequential word reads and streams each returned word into the cache data array, then commits the tag.
- Also forwards single-cycle write-through stores to memory while idle; memory never sees a read and a write in the same cycle.
- Sits between the I-cache/D-cache controllers and the shared memory; one instance per cache.

---
 rtl/cache_pkg.sv | 22 ++
 rtl/fill_counter.sv | 37 +++
 rtl/cache_fill_fsm.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
`default_nettype none
// cache_pkg: shared cache fill types, block geometry and block-base helper.
// Rev 1.0
package cache_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   localparam int ADDR_W          = 16;
   localparam int WORDS_PER_BLOCK = 8;
   localparam int BLOCK_BYTES     = 2 * WORDS_PER_BLOCK;
   localparam int OFFSET_BITS     = $clog2(BLOCK_BYTES);

   // Also used by the tag logic, so both sides agree on block alignment.
   function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fill_counter.sv
`default_nettype none
// fill_counter: clearable up-counter used for fill issue and return tracking.
// Rev 1.0
module fill_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule
`default_nettype wire

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// cache_fill_fsm: block-fill initiator with idle-time write-through store forwarding.
// Rev 1.0
module cache_fill_fsm
   import cache_pkg::state_t, cache_pkg::IDLE, cache_pkg::FILL, cache_pkg::block_base;
#(
   parameter int ADDR_WIDTH      = cache_pkg::ADDR_W,
   parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  miss_detected,
   input  logic [ADDR_WIDTH-1:0] miss_address,
   input  logic                  st_req,
   input  logic [ADDR_WIDTH-1:0] st_addr,
   input  logic [15:0]           st_data,
   output logic                  st_ack,
   output logic                  fsm_busy,
   output logic                  write_data_array,
   output logic                  write_tag_array,
   output logic [ADDR_WIDTH-1:0] fill_word_addr,
   output logic [15:0]           fill_data,
   output logic                  mem_en,
   output logic                  mem_wr,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [15:0]           mem_wdata,
   input  logic [15:0]           mem_rdata,
   input  logic                  mem_data_valid
);

   localparam int CNT_W = $clog2(WORDS_PER_BLOCK) + 1;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [CNT_W-1:0]      issue_cnt, ret_cnt;
   logic                  cnt_clr, issue_inc, ret_inc;
   logic                  issue_done, ret_last;
   logic [ADDR_WIDTH-1:0] issue_off, ret_off;
   logic                  st_addr_unused;

   assign st_addr_unused = st_addr[0];

   fill_counter #(.WIDTH(CNT_W)) u_issue_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (issue_inc),
      .count (issue_cnt)
   );

   fill_counter #(.WIDTH(CNT_W)) u_ret_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (ret_inc),
      .count (ret_cnt)
   );

   assign issue_done = (issue_cnt == CNT_W'(WORDS_PER_BLOCK));
   assign ret_last   = (ret_cnt == CNT_W'(WORDS_PER_BLOCK - 1));
   assign issue_off  = ADDR_WIDTH'({issue_cnt, 1'b0});
   assign ret_off    = ADDR_WIDTH'({ret_cnt, 1'b0});

   always_comb begin
      state_d          = state_q;
      base_d           = base_q;
      cnt_clr          = 1'b0;
      issue_inc        = 1'b0;
      ret_inc          = 1'b0;
      st_ack           = 1'b0;
      fsm_busy         = 1'b0;
      write_data_array = 1'b0;
      write_tag_array  = 1'b0;
      fill_word_addr   = '0;
      fill_data        = '0;
      mem_en           = 1'b0;
      mem_wr           = 1'b0;
      mem_addr         = '0;
      mem_wdata        = '0;
      // Outputs stay quiet for as long as reset is held, whatever the inputs do.
      if (rst_n) begin
         case (state_q)
            IDLE: begin
               if (miss_detected) begin
                  state_d  = FILL;
                  base_d   = block_base(miss_address);
                  cnt_clr  = 1'b1;
                  fsm_busy = 1'b1;
               end else if (st_req) begin
                  mem_en    = 1'b1;
                  mem_wr    = 1'b1;
                  mem_addr  = {st_addr[ADDR_WIDTH-1:1], 1'b0};
                  mem_wdata = st_data;
                  st_ack    = 1'b1;
               end
            end
            FILL: begin
               fsm_busy = 1'b1;
               if (!issue_done) begin
                  mem_en    = 1'b1;
                  mem_addr  = base_q + issue_off;
                  issue_inc = 1'b1;
               end
               if (mem_data_valid) begin
                  write_data_array = 1'b1;
                  fill_data        = mem_rdata;
                  fill_word_addr   = base_q + ret_off;
                  ret_inc          = 1'b1;
                  if (ret_last) begin
                     write_tag_array = 1'b1;
                     state_d         = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
      end
   end

endmodule
`default_nettype wire
